tt_um_accum_seq_jellyant: RTL



---
 rtl/tt_um_accum_seq_jellyant_if.sv | 29 ++
 rtl/tt_um_accum_seq_jellyant.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_accum_seq_jellyant_if.sv
// Tile pin bundle for the accumulate sequencer: the operand/count byte, the
// strobe byte, and the result/status/output-enable bytes.
// master = the side driving the tile inputs, slave = the tile itself.
interface tt_um_accum_seq_jellyant_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_accum_seq_jellyant.sv
// Accumulate sequencer for the shared 8-bit adder.
// A start latches a beat count from ui_in; that many valid beats are then
// summed through one adder (wrapping or saturating), with sticky overflow.
// done pulses one cycle after the final beat and the result stays on uo_out
// until the next accepted start.
// Optional feature macro: BEAT_TIMEOUT_EN -- adds an idle-beat watchdog in
// ACCUM that aborts the run and raises tmo_err after TIMEOUT_CYC idle cycles.
module tt_um_accum_seq_jellyant #(
    parameter int SATURATE    = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    tt_um_accum_seq_jellyant_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Last idle count before the watchdog fires (counter starts at 0).
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 32'sd1);

    // One adder beat: returns {carry, result}; result clamps on carry when saturating.
    function automatic logic [8:0] beat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[8] && (SATURATE != 32'sd0)) begin
            return {1'b1, 8'hFF};
        end else begin
            return sum;
        end
    endfunction

    state_t     state_r;
    logic [7:0] acc_r;
    logic [7:0] remaining_r;
    logic       ovf_r;
    logic       busy_r;
    logic       done_r;
    logic       tmo_bit_s;

    logic       start_s;
    logic       valid_s;
    logic       abort_s;
    logic [8:0] sum_s;
    logic       unused_s;

    assign start_s = bus.uio_in[0];
    assign valid_s = bus.uio_in[1];
    assign abort_s = bus.uio_in[2];
    assign sum_s   = beat_add(acc_r, bus.ui_in);

`ifdef BEAT_TIMEOUT_EN
    logic [7:0] idle_cnt_r;
    logic       tmo_err_r;
    assign tmo_bit_s = tmo_err_r;
    assign unused_s  = &{1'b0, bus.ena, bus.uio_in[7:3]};
`else
    assign tmo_bit_s = 1'b0;
    assign unused_s  = &{1'b0, bus.ena, bus.uio_in[7:3], TMO_LAST};
`endif

    // Sequencer FSM: state, accumulator, beat counter and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= 8'd0;
            remaining_r <= 8'd0;
            ovf_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef BEAT_TIMEOUT_EN
            idle_cnt_r  <= 8'd0;
            tmo_err_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_s) begin
                        acc_r <= 8'd0;
                        ovf_r <= 1'b0;
`ifdef BEAT_TIMEOUT_EN
                        tmo_err_r  <= 1'b0;
                        idle_cnt_r <= 8'd0;
`endif
                        if (bus.ui_in != 8'd0) begin
                            remaining_r <= bus.ui_in;
                            state_r     <= ST_ACCUM;
                            busy_r      <= 1'b1;
                        end else begin
                            remaining_r <= 8'd0;
                            state_r     <= ST_DONE;
                            done_r      <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_ACCUM: begin
                    if (abort_s) begin
                        acc_r       <= 8'd0;
                        ovf_r       <= 1'b0;
                        remaining_r <= 8'd0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (valid_s) begin
                        acc_r       <= sum_s[7:0];
                        ovf_r       <= ovf_r | sum_s[8];
                        remaining_r <= remaining_r - 8'd1;
`ifdef BEAT_TIMEOUT_EN
                        idle_cnt_r  <= 8'd0;
`endif
                        if (remaining_r == 8'd1) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_ACCUM;
                        end
                    end else begin
`ifdef BEAT_TIMEOUT_EN
                        if (idle_cnt_r == TMO_LAST) begin
                            tmo_err_r   <= 1'b1;
                            acc_r       <= 8'd0;
                            remaining_r <= 8'd0;
                            busy_r      <= 1'b0;
                            state_r     <= ST_IDLE;
                        end else begin
                            idle_cnt_r <= idle_cnt_r + 8'd1;
                        end
`else
                        state_r <= ST_ACCUM;
`endif
                    end
                end

                ST_DONE: begin
                    // Start is deliberately not sampled here; it must come in IDLE.
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.uo_out  = acc_r;
    assign bus.uio_out = {tmo_bit_s, ovf_r, done_r, busy_r, 4'h0};
    assign bus.uio_oe  = 8'hF0;

endmodule
